int_div_prep: RTL and testbench

INT_DIV_PREP -- requirements
Module: int_div_prep

---
 rtl/int_div_prep_pkg.sv | 31 +++
 rtl/river_cfg_pkg.sv | 4 +
 rtl/int_div_prep_cond.sv | 38 +++
 rtl/int_div_prep.sv | 95 +++++++++
 tb/tb_int_div_prep.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/int_div_prep_pkg.sv
// Divider-prep queue entry layout and operand conditioning helper.
// RIVER_DIV_DBG_EN adds raw operand copies to each entry for error reporting.
package int_div_prep_pkg;
   import river_cfg_pkg::RISCV_ARCH;

   typedef struct packed {
      logic                  rv32;
      logic                  resid;
      logic                  invert;
      logic                  div_on_zero;
      logic                  overflow;
      logic [RISCV_ARCH-1:0] divident;
      logic [RISCV_ARCH-1:0] divisor;
`ifdef RIVER_DIV_DBG_EN
      logic [RISCV_ARCH-1:0] a1_dbg;
      logic [RISCV_ARCH-1:0] a2_dbg;
`endif
   } div_entry_t;

   localparam div_entry_t DIV_ENTRY_RESET = '0;

   // 32-bit ops use only the low word, extended per signedness.
   function automatic logic [RISCV_ARCH-1:0] cond_operand(input logic [RISCV_ARCH-1:0] a,
                                                          input logic rv32,
                                                          input logic is_signed);
      logic [RISCV_ARCH-1:0] r;
      r = a;
      if (rv32) r = {{(RISCV_ARCH-32){is_signed & a[31]}}, a[31:0]};
      return r;
   endfunction
endpackage

// File: rtl/river_cfg_pkg.sv
// Core-wide architecture configuration shared by the execute-stage blocks.
package river_cfg_pkg;
   localparam int RISCV_ARCH = 64;
endpackage

// File: rtl/int_div_prep_cond.sv
// Combinational operand conditioning: width/sign extension, magnitudes and
// special-case flags for the divider. RIVER_DIV_DBG_EN keeps raw operands.
module int_div_prep_cond
   import int_div_prep_pkg::*;
(
   input  logic        rv32,
   input  logic        is_unsigned,
   input  logic        resid,
   input  logic [63:0] a1,
   input  logic [63:0] a2,
   output div_entry_t  entry
);
   logic [63:0] a1c, a2c, min_neg;
   logic        neg1, neg2, doz;

   always_comb begin
      a1c     = cond_operand(a1, rv32, !is_unsigned);
      a2c     = cond_operand(a2, rv32, !is_unsigned);
      neg1    = !is_unsigned & a1c[63];
      neg2    = !is_unsigned & a2c[63];
      doz     = (a2c == '0);
      min_neg = rv32 ? {{33{1'b1}}, 31'b0} : {1'b1, 63'b0};

      entry             = DIV_ENTRY_RESET;
      entry.rv32        = rv32;
      entry.resid       = resid;
      entry.div_on_zero = doz;
      entry.overflow    = !is_unsigned & (a1c == min_neg) & (&a2c);
      // Remainder takes the dividend's sign; quotient the xor of both.
      entry.invert      = !is_unsigned & !doz & (resid ? neg1 : (neg1 ^ neg2));
      entry.divident    = neg1 ? (~a1c + 64'd1) : a1c;
      entry.divisor     = neg2 ? (~a2c + 64'd1) : a2c;
`ifdef RIVER_DIV_DBG_EN
      entry.a1_dbg      = a1;
      entry.a2_dbg      = a2;
`endif
   end
endmodule

// File: rtl/int_div_prep.sv
// Divider input queue: conditions operands on push and presents the FIFO head
// to the divider. RIVER_DIV_DBG_EN drives raw operands on o_a1_dbg/o_a2_dbg.
module int_div_prep
   import int_div_prep_pkg::*;
#(
   parameter int ENTRIES = 2
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic        i_flush,
   input  logic        i_ena,
   output logic        o_ready,
   input  logic        i_rv32,
   input  logic        i_unsigned,
   input  logic        i_residual,
   input  logic [63:0] i_a1,
   input  logic [63:0] i_a2,
   output logic        o_valid,
   input  logic        i_div_ready,
   output logic        o_rv32,
   output logic        o_resid,
   output logic        o_invert,
   output logic        o_div_on_zero,
   output logic        o_overflow,
   output logic [63:0] o_divident,
   output logic [63:0] o_divisor,
   output logic [63:0] o_a1_dbg,
   output logic [63:0] o_a2_dbg
);
   localparam int AW = $clog2(ENTRIES);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(ENTRIES);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop;
   div_entry_t    push_entry, head;
   div_entry_t    mem [ENTRIES];

   int_div_prep_cond u_cond (
      .rv32        (i_rv32),
      .is_unsigned (i_unsigned),
      .resid       (i_residual),
      .a1          (i_a1),
      .a2          (i_a2),
      .entry       (push_entry)
   );

   assign o_ready = (count < FULL);
   assign o_valid = (count != '0);
   assign push    = i_ena & o_ready & !i_flush;
   assign pop     = o_valid & i_div_ready;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: every read is masked by the occupancy count.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   assign head = o_valid ? mem[rd_ptr] : DIV_ENTRY_RESET;

   assign o_rv32        = head.rv32;
   assign o_resid       = head.resid;
   assign o_invert      = head.invert;
   assign o_div_on_zero = head.div_on_zero;
   assign o_overflow    = head.overflow;
   assign o_divident    = head.divident;
   assign o_divisor     = head.divisor;
`ifdef RIVER_DIV_DBG_EN
   assign o_a1_dbg      = head.a1_dbg;
   assign o_a2_dbg      = head.a2_dbg;
`else
   assign o_a1_dbg      = '0;
   assign o_a2_dbg      = '0;
`endif
endmodule

// File: tb/tb_int_div_prep.sv
// Scoreboard bench for int_div_prep: directed vectors, expected entries queued
// at acceptance and compared by a monitor whenever the divider takes the head.
module tb_int_div_prep;
   typedef struct packed {
      logic        rv32, resid, invert, doz, ovf;
      logic [63:0] dvd, dvs, a1d, a2d;
   } exp_t;

   logic        i_clk = 0, i_nrst = 0, i_flush = 0, i_ena = 0;
   logic        i_rv32 = 0, i_unsigned = 0, i_residual = 0, i_div_ready = 0;
   logic [63:0] i_a1 = '0, i_a2 = '0;
   logic        o_ready, o_valid, o_rv32, o_resid, o_invert, o_div_on_zero, o_overflow;
   logic [63:0] o_divident, o_divisor, o_a1_dbg, o_a2_dbg;

   int   n_cmp = 0, n_bad = 0;
   exp_t exp_q[$];

   int_div_prep #(.ENTRIES(2)) dut (
      .i_clk(i_clk), .i_nrst(i_nrst), .i_flush(i_flush), .i_ena(i_ena), .o_ready(o_ready),
      .i_rv32(i_rv32), .i_unsigned(i_unsigned), .i_residual(i_residual),
      .i_a1(i_a1), .i_a2(i_a2), .o_valid(o_valid), .i_div_ready(i_div_ready),
      .o_rv32(o_rv32), .o_resid(o_resid), .o_invert(o_invert),
      .o_div_on_zero(o_div_on_zero), .o_overflow(o_overflow),
      .o_divident(o_divident), .o_divisor(o_divisor),
      .o_a1_dbg(o_a1_dbg), .o_a2_dbg(o_a2_dbg)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [263:0] got, input logic [263:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   function automatic exp_t mk(input logic rv32, resid, inv, doz, ovf,
                               input logic [63:0] dvd, dvs, a1, a2);
      exp_t e;
      e = {rv32, resid, inv, doz, ovf, dvd, dvs, 64'd0, 64'd0};
`ifdef RIVER_DIV_DBG_EN
      e.a1d = a1;
      e.a2d = a2;
`else
      if (a1 == a2) e.a1d = '0;
`endif
      return e;
   endfunction

   function automatic exp_t outs();
      return {o_rv32, o_resid, o_invert, o_div_on_zero, o_overflow,
              o_divident, o_divisor, o_a1_dbg, o_a2_dbg};
   endfunction

   // Monitor: the head is consumed at the next rising edge.
   always @(negedge i_clk) begin
      if (i_nrst && o_valid && i_div_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_delivery", 264'(outs()), 264'd0);
            if (outs() == '0) begin
               n_bad++;
               $display("FAIL unexpected_delivery: got valid entry expected none");
            end
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("delivered_entry", 264'(outs()), 264'(e));
         end
      end
   end

   task automatic push_op(input logic rv32, uns, resid, input logic [63:0] a1, a2,
                          input exp_t e, input bit track);
      bit ok;
      ok = 0;
      i_rv32 = rv32; i_unsigned = uns; i_residual = resid; i_a1 = a1; i_a2 = a2;
      i_ena = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge i_clk);
         if (o_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL push_timeout: got o_ready=0 expected 1 within 20 cycles");
      end else begin
         @(posedge i_clk);
         if (track) exp_q.push_back(e);
      end
      #1 i_ena = 0;
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge i_clk);
      #1 chk(name, 264'(exp_q.size()), 264'd0);
   endtask

   localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
   exp_t v1, v2, v3, v4, v5, v6, v7, v8, v9;

   initial begin
      v1 = mk(0,0,1,0,0, 64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      v2 = mk(1,0,0,0,1, 64'h8000_0000, 64'd1, 64'h8000_0000, 64'hFFFF_FFFF);
      v3 = mk(0,0,0,1,0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0);
      v4 = mk(1,0,0,0,0, 64'hFFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'h1_0000_0003);
      v5 = mk(0,1,1,0,0, 64'd9, 64'd4, 64'hFFFF_FFFF_FFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFFC);
      v6 = mk(0,0,1,0,0, 64'd10, 64'd3, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD);
      v7 = mk(0,0,0,0,1, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, M1);
      v8 = mk(1,1,1,0,0, 64'd10, 64'd3, 64'h1234_5678_FFFF_FFF6, 64'hDEAD_0000_0000_0003);
      v9 = mk(0,0,0,0,0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);

      // Reset state with no clock edge relevance.
      #2;
      chk("reset_valid", 264'(o_valid), 264'd0);
      chk("reset_ready", 264'(o_ready), 264'd1);
      chk("reset_outputs", 264'(outs()), 264'd0);
      @(negedge i_clk); i_nrst = 1; i_div_ready = 1;
      @(posedge i_clk); #1;

      // Latency: empty before acceptance, valid one cycle after.
      chk("empty_before_push", 264'(o_valid), 264'd0);
      push_op(0,0,0, v1.a1d | 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, v1, 1);
      chk("latency1_valid", 264'(o_valid), 264'd1);
      wait_drain("drain_v1");
      push_op(1,0,0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, v2, 1);
      push_op(0,0,0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, v3, 1);
      push_op(1,1,0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h1_0000_0003, v4, 1);
      push_op(0,0,0, 64'h8000_0000_0000_0000, M1, v7, 1);
      push_op(1,0,1, 64'h1234_5678_FFFF_FFF6, 64'hDEAD_0000_0000_0003, v8, 1);
      wait_drain("drain_basic");

      // Backpressure: A,B fill the queue, C waits, then strict order.
      i_div_ready = 0;
      push_op(0,0,1, 64'hFFFF_FFFF_FFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFFC, v5, 1);
      push_op(0,0,0, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD, v6, 1);
      chk("full_ready", 264'(o_ready), 264'd0);
      i_rv32 = 0; i_unsigned = 1; i_residual = 0; i_a1 = 64'hFFFF_FFFF_FFFF_FFF9; i_a2 = 64'd2;
      i_ena = 1;
      repeat (2) @(posedge i_clk);
      #1;
      chk("hold_head", 264'(outs()), 264'(v5));
      chk("hold_ready", 264'(o_ready), 264'd0);
      i_div_ready = 1;
      push_op(0,1,0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, v9, 1);
      wait_drain("drain_order");

      // Flush while full with a concurrent push.
      i_div_ready = 0;
      push_op(0,0,0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, v1, 0);
      push_op(1,0,0, 64'h8000_0000, 64'hFFFF_FFFF, v2, 0);
      chk("flush_pre_ready", 264'(o_ready), 264'd0);
      i_rv32 = 0; i_unsigned = 0; i_residual = 0; i_a1 = 64'hFFFF_FFFF_FFFF_FFFB; i_a2 = 64'd0;
      i_flush = 1; i_ena = 1;
      @(posedge i_clk); #1;
      i_flush = 0; i_ena = 0;
      chk("flush_valid", 264'(o_valid), 264'd0);
      chk("flush_ready", 264'(o_ready), 264'd1);
      chk("flush_outputs", 264'(outs()), 264'd0);
      i_div_ready = 1;
      repeat (3) @(posedge i_clk);
      #1 chk("flush_no_entry", 264'(o_valid), 264'd0);

      // Reset pulse with two entries queued.
      i_div_ready = 0;
      push_op(1,1,0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h1_0000_0003, v4, 0);
      push_op(0,0,0, 64'h8000_0000_0000_0000, M1, v7, 0);
      chk("rst_pre_valid", 264'(o_valid), 264'd1);
      i_nrst = 0;
      #1;
      chk("rst_async_valid", 264'(o_valid), 264'd0);
      chk("rst_async_ready", 264'(o_ready), 264'd1);
      chk("rst_async_outputs", 264'(outs()), 264'd0);
      @(negedge i_clk); i_nrst = 1; i_div_ready = 1;
      repeat (3) @(posedge i_clk);
      #1 chk("rst_no_entry", 264'(o_valid), 264'd0);
      push_op(0,0,0, 64'd10, 64'hFFFF_FFFF_FFFF_FFFD, v6, 1);
      wait_drain("drain_post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog");
   end
endmodule
